fetch_prefetch_unit: RTL and testbench

- Instruction fetch stage sitting directly upstream of the main controller/decode logic.
- Issues word fetches to a variable-latency, in-order instruction memory and buffers returned words in a QDEPTH-entry prefetch queue.
- Presents one instruction per cycle with its PC and PC+4; NextInstruct is the link value used by JAL.
- Accepts a branch/jump redirect that flushes buffered and in-flight fetches.

---
 rtl/fetch_prefetch_unit.sv | 141 ++++++++++++++
 tb/tb_fetch_prefetch_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch_unit.sv
// Instruction fetch stage with a small prefetch queue.
// Issues word fetches to an in-order, variable-latency instruction memory,
// buffers returned words, and hands one instruction per cycle to decode
// together with its PC and PC+4. A redirect flushes the queue and marks
// every request still in flight as stale, so its response is discarded.
module fetch_prefetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic        MemGnt,
    input  logic        MemRespValid,
    input  logic [31:0] MemRespData,
    input  logic        Redirect,
    input  logic [31:0] RedirectPC,
    input  logic        DecStall,
    output logic        InstValid,
    output logic [31:0] Instruction,
    output logic [31:0] InstPC,
    output logic [31:0] NextInstruct
);

    // Counters hold 0..QDEPTH; queue pointers index QDEPTH (power of two) slots.
    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned PW = $clog2(QDEPTH);
    localparam logic [CW:0] DEPTH = (CW + 1)'(QDEPTH);

    // Architectural state
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   head_pc_q,  head_pc_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    logic [CW-1:0] count_q,    count_d;
    logic [PW-1:0] rd_ptr_q,   rd_ptr_d;
    logic [PW-1:0] wr_ptr_q,   wr_ptr_d;
    logic [31:0]   queue_q [QDEPTH];

    // Per-cycle events
    logic [CW:0]   occupancy;
    logic          issue;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [31:0]   redirect_pc_aligned;

    // The two low address bits of a redirect target are don't-care.
    logic          redirect_pc_unused;
    assign redirect_pc_unused  = ^RedirectPC[1:0];
    assign redirect_pc_aligned = {RedirectPC[31:2], 2'b00};

    // Credit check on registered values only: a pop this cycle frees a slot next cycle.
    assign occupancy = {1'b0, inflight_q} + {1'b0, count_q};
    assign MemReq    = !Reset && !Redirect && (occupancy < DEPTH);
    assign MemAddr   = fetch_pc_q;
    assign issue     = MemReq && MemGnt;

    // Responses for requests issued before a redirect are stale and dropped.
    assign resp_drop = MemRespValid && (drop_cnt_q != '0);
    assign push      = MemRespValid && !resp_drop && !Redirect;

    // Head of queue presented to decode; NOOP when empty, no bypass of arriving data.
    assign InstValid    = (count_q != '0);
    assign pop          = InstValid && !DecStall && !Redirect;
    assign Instruction  = InstValid ? queue_q[rd_ptr_q] : 32'h0000_0000;
    assign InstPC       = head_pc_q;
    assign NextInstruct = head_pc_q + 32'd4;

    // Next-state computation; redirect overrides issue, push and pop.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        fetch_pc_d = fetch_pc_q;
        head_pc_d  = head_pc_q;
        inflight_d = inflight_q;
        drop_cnt_d = drop_cnt_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (Redirect) begin
            fetch_pc_d = redirect_pc_aligned;
            head_pc_d  = redirect_pc_aligned;
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            // Everything still outstanding after this cycle's response is stale,
            // including requests that were already marked stale earlier.
            inflight_d = inflight_q - CW'(MemRespValid);
            drop_cnt_d = inflight_q - CW'(MemRespValid);
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            inflight_d = inflight_q + CW'(issue) - CW'(MemRespValid);
            if (resp_drop) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                head_pc_d = head_pc_q + 32'd4;
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers with synchronous reset; reset beats redirect.
    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
        if (Reset) begin
            fetch_pc_q <= RESET_PC;
            head_pc_q  <= RESET_PC;
            inflight_q <= '0;
            drop_cnt_q <= '0;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            head_pc_q  <= head_pc_d;
            inflight_q <= inflight_d;
            drop_cnt_q <= drop_cnt_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // Queue storage: write accepted response words at the tail.
    always_ff @(posedge Clk) begin
        // NOTE: storage is not reset; count_q gates its contents, so stale words are never visible.
        if (push) begin
            queue_q[wr_ptr_q] <= MemRespData;
        end
    end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an in-order, fixed-latency
// instruction memory model and an in-order consumer monitor.
module tb_fetch_prefetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          QDEPTH   = 2;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        MemReq;
    logic [31:0] MemAddr;
    logic        MemGnt;
    logic        MemRespValid;
    logic [31:0] MemRespData;
    logic        Redirect;
    logic [31:0] RedirectPC;
    logic        DecStall;
    logic        InstValid;
    logic [31:0] Instruction;
    logic [31:0] InstPC;
    logic [31:0] NextInstruct;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_prefetch_unit #(
        .RESET_PC (RESET_PC),
        .QDEPTH   (QDEPTH)
    ) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .MemReq       (MemReq),
        .MemAddr      (MemAddr),
        .MemGnt       (MemGnt),
        .MemRespValid (MemRespValid),
        .MemRespData  (MemRespData),
        .Redirect     (Redirect),
        .RedirectPC   (RedirectPC),
        .DecStall     (DecStall),
        .InstValid    (InstValid),
        .Instruction  (Instruction),
        .InstPC       (InstPC),
        .NextInstruct (NextInstruct)
    );

    always #5 Clk = ~Clk;

    // Instruction word stored at a byte address: 0x20080005, 0x20090007, ...
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h2008_0005 + (a >> 2) * 32'h0001_0002;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Memory model: accepted requests answer 'lat' cycles after grant, in order.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t pend[$];
    int   cyc = 0;
    int   lat = 1;

    always @(posedge Clk) begin
        if (Reset) begin
            pend.delete();
        end else begin
            if (MemRespValid) void'(pend.pop_front());
            if (MemReq && MemGnt) pend.push_back(req_t'{addr: MemAddr, due: cyc + lat});
        end
        cyc++;
    end

    always @(negedge Clk) begin
        if (!Reset && pend.size() > 0 && pend[0].due <= cyc) begin
            MemRespValid = 1'b1;
            MemRespData  = word_at(pend[0].addr);
        end else begin
            MemRespValid = 1'b0;
            MemRespData  = 32'hDEAD_BEEF;
        end
    end

    // Consumer model: every consumed instruction must be the next PC in program order.
    logic [31:0] exp_pc = RESET_PC;

    task automatic monitor();
        int occ;
        if (Reset) begin
            exp_pc = RESET_PC;
        end else begin
            occ = int'(dut.count_q) + int'(dut.inflight_q);
            if (occ > QDEPTH) check("overflow", occ, QDEPTH);
            if (!InstValid) check("noop_when_empty", Instruction, 32'h0);
            if (Redirect) begin
                exp_pc = {RedirectPC[31:2], 2'b00};
            end else if (InstValid && !DecStall) begin
                check("pop_pc",   InstPC,       exp_pc);
                check("pop_word", Instruction,  word_at(exp_pc));
                check("pop_next", NextInstruct, exp_pc + 32'd4);
                exp_pc = exp_pc + 32'd4;
            end
        end
    endtask

    // Inputs are driven 1 unit after the rising edge; outputs sampled 1 unit after the falling edge.
    task automatic sample();
        @(negedge Clk);
        #1;
        monitor();
    endtask

    task automatic next();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        Reset      = 1'b1;
        Redirect   = 1'b0;
        RedirectPC = 32'h0;
        DecStall   = 1'b0;
        MemGnt     = 1'b1;
        repeat (n) begin
            sample();
            check("rst_memreq", MemReq, 0);
            next();
        end
        Reset = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Basic streaming, 1-cycle memory latency
        lat = 1;
        do_reset(2);
        sample();
        check("t1_c0_valid", InstValid, 0);
        check("t1_c0_inst", Instruction, 32'h0);
        check("t1_c0_pc", InstPC, RESET_PC);
        check("t1_c0_next", NextInstruct, RESET_PC + 32'd4);
        check("t1_c0_req", MemReq, 1);
        check("t1_c0_addr", MemAddr, RESET_PC);
        next();
        sample();
        check("t1_c1_valid", InstValid, 0);
        check("t1_c1_req", MemReq, 1);
        check("t1_c1_addr", MemAddr, 32'h4);
        next();
        sample();
        check("t1_c2_valid", InstValid, 1);
        check("t1_c2_pc", InstPC, 32'h0);
        check("t1_c2_next", NextInstruct, 32'h4);
        check("t1_c2_inst", Instruction, 32'h2008_0005);
        check("t1_c2_req_credit", MemReq, 0);
        next();
        sample();
        check("t1_c3_pc", InstPC, 32'h4);
        check("t1_c3_inst", Instruction, 32'h2009_0007);
        check("t1_c3_req", MemReq, 1);
        check("t1_c3_addr", MemAddr, 32'h8);
        next();
        sample();
        check("t1_c4_valid", InstValid, 0);
        check("t1_c4_addr", MemAddr, 32'hC);
        next();
        repeat (10) begin sample(); next(); end

        // Decode stall fills the queue and blocks issue
        lat = 1;
        do_reset(1);
        DecStall = 1'b1;
        sample(); next();
        sample(); next();
        sample();
        check("t2_c2_req_full", MemReq, 0);
        next();
        sample();
        check("t2_c3_valid", InstValid, 1);
        check("t2_c3_pc", InstPC, 32'h0);
        check("t2_c3_req", MemReq, 0);
        next();
        sample(); next();
        sample();
        check("t2_c5_pc_held", InstPC, 32'h0);
        check("t2_c5_inst", Instruction, 32'h2008_0005);
        check("t2_c5_req", MemReq, 0);
        next();
        DecStall = 1'b0;
        sample();
        check("t2_c6_req_no_same_cycle_credit", MemReq, 0);
        next();
        sample();
        check("t2_c7_pc", InstPC, 32'h4);
        check("t2_c7_req", MemReq, 1);
        check("t2_c7_addr", MemAddr, 32'h8);
        next();
        repeat (8) begin sample(); next(); end

        // Redirect with two requests in flight, 3-cycle latency
        lat = 3;
        do_reset(1);
        sample();
        check("t3_c0_addr", MemAddr, 32'h0);
        next();
        sample();
        check("t3_c1_addr", MemAddr, 32'h4);
        next();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0100;
        sample();
        check("t3_c2_req_redirect", MemReq, 0);
        next();
        Redirect = 1'b0;
        sample();
        check("t3_c3_req", MemReq, 0);
        check("t3_c3_valid", InstValid, 0);
        check("t3_c3_pc", InstPC, 32'h100);
        next();
        sample();
        check("t3_c4_req", MemReq, 1);
        check("t3_c4_addr", MemAddr, 32'h100);
        check("t3_c4_valid_drop", InstValid, 0);
        next();
        sample();
        check("t3_c5_valid_drop", InstValid, 0);
        check("t3_c5_addr", MemAddr, 32'h104);
        next();
        sample();
        check("t3_c6_req", MemReq, 0);
        next();
        sample();
        check("t3_c7_valid", InstValid, 0);
        next();
        sample();
        check("t3_c8_valid", InstValid, 1);
        check("t3_c8_pc", InstPC, 32'h100);
        check("t3_c8_next", NextInstruct, 32'h104);
        check("t3_c8_inst", Instruction, word_at(32'h100));
        next();
        repeat (6) begin sample(); next(); end

        // Redirect in the same cycle as a response, with a valid head
        lat = 1;
        do_reset(1);
        sample(); next();
        sample(); next();
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0200;
        sample();
        check("t4_c2_head_valid", InstValid, 1);
        check("t4_c2_req", MemReq, 0);
        next();
        Redirect = 1'b0;
        sample();
        check("t4_c3_valid", InstValid, 0);
        check("t4_c3_pc", InstPC, 32'h200);
        check("t4_c3_next", NextInstruct, 32'h204);
        check("t4_c3_req", MemReq, 1);
        check("t4_c3_addr", MemAddr, 32'h200);
        next();
        sample();
        check("t4_c4_valid", InstValid, 0);
        next();
        sample();
        check("t4_c5_valid", InstValid, 1);
        check("t4_c5_pc", InstPC, 32'h200);
        check("t4_c5_inst", Instruction, word_at(32'h200));
        next();
        repeat (4) begin sample(); next(); end

        // Unaligned redirect, back-to-back redirects, address wrap
        lat = 1;
        do_reset(1);
        Redirect   = 1'b1;
        RedirectPC = 32'h0000_0103;
        sample();
        check("t5_c0_req", MemReq, 0);
        next();
        RedirectPC = 32'hFFFF_FFFC;
        sample();
        check("t5_c1_addr_aligned", MemAddr, 32'h100);
        check("t5_c1_pc_aligned", InstPC, 32'h100);
        check("t5_c1_req", MemReq, 0);
        next();
        Redirect = 1'b0;
        sample();
        check("t5_c2_req", MemReq, 1);
        check("t5_c2_addr_last_wins", MemAddr, 32'hFFFF_FFFC);
        check("t5_c2_next_wrap", NextInstruct, 32'h0);
        next();
        sample();
        check("t5_c3_addr_wrap", MemAddr, 32'h0);
        check("t5_c3_req", MemReq, 1);
        next();
        sample();
        check("t5_c4_valid", InstValid, 1);
        check("t5_c4_pc", InstPC, 32'hFFFF_FFFC);
        check("t5_c4_inst", Instruction, word_at(32'hFFFF_FFFC));
        next();
        sample();
        check("t5_c5_pc_wrap", InstPC, 32'h0);
        check("t5_c5_next", NextInstruct, 32'h4);
        next();
        repeat (4) begin sample(); next(); end

        // Request held until granted
        lat = 1;
        do_reset(1);
        MemGnt = 1'b0;
        sample();
        check("t6_c0_req", MemReq, 1);
        check("t6_c0_addr", MemAddr, 32'h0);
        next();
        sample();
        check("t6_c1_addr_held", MemAddr, 32'h0);
        check("t6_c1_valid", InstValid, 0);
        next();
        MemGnt = 1'b1;
        sample();
        check("t6_c2_addr", MemAddr, 32'h0);
        next();
        sample();
        check("t6_c3_addr", MemAddr, 32'h4);
        check("t6_c3_valid", InstValid, 0);
        next();
        sample();
        check("t6_c4_valid", InstValid, 1);
        check("t6_c4_pc", InstPC, 32'h0);
        next();

        // Reset mid-stream with a buffered word and a request in flight
        lat = 3;
        do_reset(1);
        DecStall = 1'b1;
        sample(); next();
        sample(); next();
        sample(); next();
        sample();
        check("t7_c3_valid", InstValid, 0);
        next();
        Reset = 1'b1;
        sample();
        check("t7_c4_req_in_reset", MemReq, 0);
        check("t7_c4_valid_before", InstValid, 1);
        next();
        sample();
        check("t7_c5_valid", InstValid, 0);
        check("t7_c5_inst", Instruction, 32'h0);
        check("t7_c5_req", MemReq, 0);
        check("t7_c5_pc", InstPC, RESET_PC);
        next();
        Reset    = 1'b0;
        DecStall = 1'b0;
        sample();
        check("t7_c6_req", MemReq, 1);
        check("t7_c6_addr", MemAddr, RESET_PC);
        check("t7_c6_valid", InstValid, 0);
        next();
        repeat (12) begin sample(); next(); end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
